memory_access: RTL and testbench

Memory-stage data-bus access unit. Takes a load/store from the M-stage pipeline register and drives the data bus through a request/response handshake. It aligns store data and byte strobes, and extracts and extends load data into ReadDataM for the writeback stage. It stalls the pipeline until the bus completes and holds the result until the pipeline advances.

---
 rtl/memory_access_pkg.sv | 20 ++
 rtl/load_extend.sv | 26 ++
 rtl/memory_access.sv | 124 ++++++++++++
 tb/tb_memory_access.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/memory_access_pkg.sv
// Shared types and constants for the memory-stage data-bus access unit.
package memory_access_pkg;

  localparam int unsigned STROBE_W = 4;

  // Encoding 3 is reserved and handled as a word access.
  typedef enum logic [1:0] {
    MSIZE_B = 2'd0,
    MSIZE_H = 2'd1,
    MSIZE_W = 2'd2
  } msize_t;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StAddr = 2'd1,
    StData = 2'd2,
    StHold = 2'd3
  } memacc_state_t;

endpackage

// File: rtl/load_extend.sv
// Load data extraction: selects the addressed byte/half/word from the raw bus word
// and sign- or zero-extends it to 32 bits.
module load_extend
  import memory_access_pkg::*;
(
  input  logic [31:0] raw,
  input  logic [1:0]  offset,
  input  logic [1:0]  msize,
  input  logic        unsigned_ld,
  output logic [31:0] result
);

  logic [31:0] shifted;

  always_comb begin
    shifted = raw >> {offset, 3'b000};
    if (msize == MSIZE_B) begin
      result = {{24{~unsigned_ld & shifted[7]}}, shifted[7:0]};
    end else if (msize == MSIZE_H) begin
      result = {{16{~unsigned_ld & shifted[15]}}, shifted[15:0]};
    end else begin
      result = shifted;
    end
  end

endmodule

// File: rtl/memory_access.sv
// Memory-stage data-bus access unit: request/response handshake, store lane alignment,
// load extension and pipeline stall. Optional MEMACC_MISALIGN_CHECK_EN enables misalign trapping.
module memory_access
  import memory_access_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                memread,
  input  logic                memwrite,
  input  logic [1:0]          msize,
  input  logic                unsignedM,
  input  logic [31:0]         ALUoutM,
  input  logic [31:0]         WriteDataM,
  input  logic                advance,
  output logic                dreq_valid,
  output logic [31:0]         dreq_addr,
  output logic                dreq_write,
  output logic [STROBE_W-1:0] dreq_strobe,
  output logic [31:0]         dreq_data,
  input  logic                addr_ok,
  input  logic                data_ok,
  input  logic [31:0]         dresp_data,
  output logic [31:0]         ReadDataM,
  output logic                mem_stall,
  output logic                misalign
);

  memacc_state_t       state_q, state_d;
  logic [31:0]         data_q;
  logic [31:0]         load_ext;
  logic                op, complete, load_done;
  logic [1:0]          offset;
  logic [STROBE_W-1:0] lanes;

  assign op     = memread | memwrite;
  assign offset = ALUoutM[1:0];

`ifdef MEMACC_MISALIGN_CHECK_EN
  logic bad_align;
  always_comb begin
    bad_align = 1'b0;
    if (msize == MSIZE_H) begin
      bad_align = offset[0];
    end else if (msize != MSIZE_B) begin
      bad_align = |offset;
    end
  end
  assign misalign = op & bad_align;
`else
  assign misalign = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    dreq_valid = 1'b0;
    complete   = 1'b0;
    unique case (state_q)
      StIdle, StAddr: begin
        dreq_valid = op & ~misalign;
        // A misaligned access never reaches the bus and retires in place.
        complete   = misalign | (dreq_valid & addr_ok & data_ok);
        if (complete) begin
          state_d = advance ? StIdle : StHold;
        end else if (dreq_valid & addr_ok) begin
          state_d = StData;
        end else if (dreq_valid) begin
          state_d = StAddr;
        end else begin
          state_d = StIdle;
        end
      end
      StData: begin
        if (data_ok) begin
          complete = 1'b1;
          state_d  = advance ? StIdle : StHold;
        end
      end
      StHold: begin
        if (advance) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign load_done = complete & memread & ~misalign;
  assign mem_stall = op & ~complete & (state_q != StHold);
  assign ReadDataM = load_done ? load_ext : data_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      if (load_done) data_q <= load_ext;
    end
  end

  load_extend u_load_extend (
    .raw         (dresp_data),
    .offset      (offset),
    .msize       (msize),
    .unsigned_ld (unsignedM),
    .result      (load_ext)
  );

  always_comb begin
    if (msize == MSIZE_B) begin
      lanes     = 4'b0001 << offset;
      dreq_data = {4{WriteDataM[7:0]}};
    end else if (msize == MSIZE_H) begin
      lanes     = 4'b0011 << {offset[1], 1'b0};
      dreq_data = {2{WriteDataM[15:0]}};
    end else begin
      lanes     = 4'b1111;
      dreq_data = WriteDataM;
    end
  end

  assign dreq_addr   = ALUoutM;
  assign dreq_write  = memwrite;
  assign dreq_strobe = memwrite ? lanes : '0;

endmodule

// File: tb/tb_memory_access.sv
// Self-checking bench for memory_access: directed cases followed by randomized transactions
// against an arithmetic reference model (honours MEMACC_MISALIGN_CHECK_EN).
module tb_memory_access;

  logic        clk, reset, memread, memwrite, unsignedM, advance;
  logic [1:0]  msize;
  logic [31:0] ALUoutM, WriteDataM, dresp_data;
  logic        addr_ok, data_ok;
  logic        dreq_valid, dreq_write, mem_stall, misalign;
  logic [31:0] dreq_addr, dreq_data, ReadDataM;
  logic [3:0]  dreq_strobe;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] last_load;

  memory_access dut (
    .clk         (clk),
    .reset       (reset),
    .memread     (memread),
    .memwrite    (memwrite),
    .msize       (msize),
    .unsignedM   (unsignedM),
    .ALUoutM     (ALUoutM),
    .WriteDataM  (WriteDataM),
    .advance     (advance),
    .dreq_valid  (dreq_valid),
    .dreq_addr   (dreq_addr),
    .dreq_write  (dreq_write),
    .dreq_strobe (dreq_strobe),
    .dreq_data   (dreq_data),
    .addr_ok     (addr_ok),
    .data_ok     (data_ok),
    .dresp_data  (dresp_data),
    .ReadDataM   (ReadDataM),
    .mem_stall   (mem_stall),
    .misalign    (misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: byte offset, size in bytes, arithmetic extraction.
  function automatic int unsigned size_bytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] raw, input int unsigned off,
                                         input logic [1:0] sz, input logic uns);
    longint unsigned v, span;
    span = 64'd1 << (8 * size_bytes(sz));
    v = (longint'(raw) >> (8 * off)) % span;
    if (!uns && v >= span / 2) v = v + (64'h1_0000_0000 - span);
    return v[31:0];
  endfunction

  function automatic logic [3:0] m_strobe(input logic wr, input logic [1:0] sz,
                                          input int unsigned off);
    if (!wr) return 4'd0;
    if (sz == 2'd0) return 4'(1 << off);
    if (sz == 2'd1) return (off >= 2) ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  function automatic logic [31:0] m_sdata(input logic [31:0] wd, input logic [1:0] sz);
    if (sz == 2'd0) return {24'd0, wd[7:0]} * 32'h0101_0101;
    if (sz == 2'd1) return {16'd0, wd[15:0]} * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic m_mis(input logic [1:0] sz, input int unsigned off);
`ifdef MEMACC_MISALIGN_CHECK_EN
    return (off % size_bytes(sz)) != 0;
`else
    return (sz == 2'd3) && 1'b0 && (off == 0);
`endif
  endfunction

  // One access: addr_ok arrives da cycles in, data_ok dd cycles after that,
  // then the pipeline withholds advance for `hold` cycles.
  task automatic run_txn(input logic rd, input logic wr, input logic [1:0] sz,
                         input logic uns, input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] rdat, input int da, input int dd, input int hold);
    logic        mis;
    int          done_c;
    int unsigned off;
    off    = int'(a[1:0]);
    mis    = m_mis(sz, off);
    done_c = mis ? 0 : da + dd;
    memread = rd; memwrite = wr; msize = sz; unsignedM = uns;
    ALUoutM = a; WriteDataM = wd; dresp_data = rdat;
    for (int c = 0; c <= done_c; c++) begin
      addr_ok = !mis && (c == da);
      data_ok = !mis && (c == done_c);
      advance = (c == done_c) && (hold == 0);
      @(negedge clk);
      chk("stall", mem_stall, c != done_c);
      chk("valid", dreq_valid, !mis && c <= da);
      chk("misalign", misalign, mis);
      if (!mis && c <= da) begin
        chk("addr", dreq_addr, a);
        chk("write", dreq_write, wr);
        chk("strobe", dreq_strobe, m_strobe(wr, sz, off));
        if (wr) chk("sdata", dreq_data, m_sdata(wd, sz));
      end
      if (c == done_c) begin
        if (rd && !mis) last_load = m_load(rdat, off, sz, uns);
        chk("rdata_done", ReadDataM, last_load);
      end
      @(posedge clk); #1;
    end
    addr_ok = 1'b0; data_ok = 1'b0;
    for (int h = 0; h < hold; h++) begin
      advance = (h == hold - 1);
      @(negedge clk);
      chk("hold_valid", dreq_valid, 1'b0);
      chk("hold_stall", mem_stall, 1'b0);
      chk("hold_rdata", ReadDataM, last_load);
      @(posedge clk); #1;
    end
    memread = 1'b0; memwrite = 1'b0; advance = 1'b0;
  endtask

  initial begin
    reset = 1'b1; memread = 1'b0; memwrite = 1'b0; msize = 2'd0; unsignedM = 1'b0;
    ALUoutM = '0; WriteDataM = '0; dresp_data = '0; advance = 1'b0;
    addr_ok = 1'b0; data_ok = 1'b0; last_load = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_valid", dreq_valid, 1'b0);
    chk("rst_stall", mem_stall, 1'b0);
    chk("rst_misalign", misalign, 1'b0);
    chk("rst_rdata", ReadDataM, 32'h0);
    @(posedge clk); #1;

    // lb at 0x1003, zero-latency completion
    run_txn(1, 0, 2'd0, 0, 32'h1003, 32'h0, 32'h80AABBCC, 0, 0, 0);
    @(negedge clk);
    chk("lb_result", ReadDataM, 32'hFFFFFF80);
    @(posedge clk); #1;

    // sh of 0x1234ABCD at 0x2002
    run_txn(0, 1, 2'd1, 0, 32'h2002, 32'h1234ABCD, 32'h0, 0, 0, 0);
    // lhu with addr_ok delayed 2 and data_ok 3 after: 5 stall cycles
    run_txn(1, 0, 2'd1, 1, 32'h3000, 32'h0, 32'h0000F00D, 2, 3, 0);
    @(negedge clk);
    chk("lhu_result", ReadDataM, 32'h0000F00D);
    @(posedge clk); #1;
    // completion with advance withheld for 3 cycles
    run_txn(1, 0, 2'd2, 0, 32'h3104, 32'h0, 32'hCAFE0123, 1, 1, 3);

    // reset while waiting for data, then a spurious data_ok
    memread = 1'b1; msize = 2'd2; ALUoutM = 32'h5000; addr_ok = 1'b1;
    @(negedge clk);
    chk("rst_txn_stall0", mem_stall, 1'b1);
    @(posedge clk); #1;
    addr_ok = 1'b0;
    @(negedge clk);
    chk("rst_txn_stall1", mem_stall, 1'b1);
    chk("rst_txn_valid", dreq_valid, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; memread = 1'b0; last_load = '0;
    data_ok = 1'b1; dresp_data = 32'hDEADBEEF;
    @(negedge clk);
    chk("spur_rdata", ReadDataM, 32'h0);
    chk("spur_stall", mem_stall, 1'b0);
    @(posedge clk); #1;
    data_ok = 1'b0;
    @(negedge clk);
    chk("spur_rdata_q", ReadDataM, 32'h0);
    @(posedge clk); #1;

    // lw at 0x4002: trapped when misalign checking is built in
    run_txn(1, 0, 2'd2, 0, 32'h4002, 32'h0, 32'h11223344, 0, 1, 0);

    for (int i = 0; i < 60; i++) begin
      logic is_rd;
      is_rd = 1'($urandom_range(0, 1));
      run_txn(is_rd, !is_rd, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              $urandom, $urandom, $urandom, int'($urandom_range(0, 2)),
              int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
